// File: rtl/load_use_scoreboard_pkg.sv
// Shared definitions for the load-use scoreboard: register addressing, tag FIFO entry
// and the hazard-cause encoding used for debug/perf visibility.
package load_use_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
  } tag_entry_t;

  typedef enum logic [1:0] {
    HzNone,
    HzRs1,
    HzRs2,
    HzFull
  } hazard_cause_e;

endpackage

// File: rtl/load_use_scoreboard_tag_fifo.sv
// In-order tag FIFO of outstanding load destinations. Supports push, pop of the head and
// dropping the youngest entry (tail-1) when a flushed load is killed in EX.
module load_use_scoreboard_tag_fifo
  import load_use_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             drop_tail,
  input  tag_entry_t       wdata,
  output tag_entry_t       head_data,
  output tag_entry_t       tail_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, tail_prev;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(DEPTH - 1) : p - 1'b1;
  endfunction

  always_comb begin
    tail_prev = ptr_dec(tail_q);
    head_d    = pop ? ptr_inc(head_q) : head_q;
    tail_d    = tail_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end else if (drop_tail) begin
      tail_d = tail_prev;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop) - CNT_W'(drop_tail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= wdata;
    end
  end

  assign head_data = mem_q[head_q];
  assign tail_data = mem_q[tail_prev];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight load destinations and stalls ID while an
// operand depends on a load whose data cannot yet be forwarded.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             ex_is_load,
  input  logic             load_done,
  output logic             stall,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             err
);

  localparam int unsigned SumW = CNT_W + 1;

  tag_entry_t       head_data, tail_data, push_entry;
  logic [CNT_W-1:0] count;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];

  logic          rel_rs1, rel_rs2, hz_rs1, hz_rs2;
  hazard_cause_e hazard_cause;
  logic          issue, push_ok, pop_ok, drop_ok, underflow, err_set, err_q;
  logic [1:0]    inc, dec;

  // A dependence releases in the cycle its data returns: it is forwardable next cycle.
  always_comb begin
    rel_rs1 = load_done && (head_data.rd == id_rs1) && (pend_q[id_rs1] == CNT_W'(1));
    rel_rs2 = load_done && (head_data.rd == id_rs2) && (pend_q[id_rs2] == CNT_W'(1));
    hz_rs1  = id_use_rs1 && (id_rs1 != REG_X0) && (pend_q[id_rs1] != '0) && !rel_rs1;
    hz_rs2  = id_use_rs2 && (id_rs2 != REG_X0) && (pend_q[id_rs2] != '0) && !rel_rs2;
    hazard_cause = HzNone;
    if (hz_rs1) begin
      hazard_cause = HzRs1;
    end else if (hz_rs2) begin
      hazard_cause = HzRs2;
    end else if (id_memread && fifo_full && !load_done) begin
      hazard_cause = HzFull;
    end
    stall = id_valid && !flush && (hazard_cause != HzNone);
  end

  always_comb begin
    issue   = id_valid && id_memread && (id_rd != REG_X0) && !stall && !flush;
    pop_ok  = load_done && !fifo_empty;
    // With one entry, a completing load and a killed load are the same load.
    drop_ok = flush && ex_is_load && !fifo_empty && !(pop_ok && (count == CNT_W'(1)));
    push_ok = issue && (!fifo_full || pop_ok);
    push_entry.rd = id_rd;
  end

  always_comb begin
    underflow = 1'b0;
    inc       = '0;
    dec       = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc = 2'(push_ok && (id_rd == REG_ADDR_W'(r)));
      dec = 2'(pop_ok && (head_data.rd == REG_ADDR_W'(r)))
          + 2'(drop_ok && (tail_data.rd == REG_ADDR_W'(r)));
      if ({1'b0, pend_q[r]} + SumW'(inc) < SumW'(dec)) begin
        underflow = 1'b1;
        pend_d[r] = pend_q[r] + CNT_W'(inc);
      end else begin
        pend_d[r] = CNT_W'({1'b0, pend_q[r]} + SumW'(inc) - SumW'(dec));
      end
    end
  end

  assign err_set = (load_done && fifo_empty && !issue) || (issue && fifo_full && !pop_ok)
                 || underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      err_q <= err_q || err_set;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  load_use_scoreboard_tag_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .pop       (pop_ok),
    .drop_tail (drop_ok),
    .wdata     (push_entry),
    .head_data (head_data),
    .tail_data (tail_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign full        = fifo_full;
  assign empty       = fifo_empty;
  assign pending_cnt = count;
  assign err         = err_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench: a queue-based reference model predicts stall and post-edge state;
// predictions are queued at drive time and compared once the edge has produced them.
module tb_load_use_scoreboard;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs1, id_use_rs2, id_memread, flush, ex_is_load, load_done;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             stall, full, empty, err;
  logic [CNT_W-1:0] pending_cnt;

  always #5 clk = ~clk;

  load_use_scoreboard #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_memread  (id_memread),
    .flush       (flush),
    .ex_is_load  (ex_is_load),
    .load_done   (load_done),
    .stall       (stall),
    .full        (full),
    .empty       (empty),
    .pending_cnt (pending_cnt),
    .err         (err)
  );

  typedef struct packed {
    logic       stall;
    logic       full;
    logic       empty;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] m_q[$];
  logic       m_err = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         stall_cycles = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
    end
  endtask

  function automatic int m_pend(input logic [4:0] r);
    int n = 0;
    foreach (m_q[i]) if (m_q[i] == r) n++;
    return n;
  endfunction

  // One ID cycle: drive, predict, sample stall, clock, compare registered state.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic mr, input logic fl, input logic exl, input logic ld);
    exp_t e;
    logic obs_stall, rel1, rel2, hz1, hz2, mstall, iss, popping, kill;
    int   sz;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_memread = mr; flush = fl; ex_is_load = exl; load_done = ld;
    #1;
    sz     = m_q.size();
    rel1   = ld && sz > 0 && m_q[0] == r1 && m_pend(r1) == 1;
    rel2   = ld && sz > 0 && m_q[0] == r2 && m_pend(r2) == 1;
    hz1    = u1 && r1 != 0 && m_pend(r1) != 0 && !rel1;
    hz2    = u2 && r2 != 0 && m_pend(r2) != 0 && !rel2;
    mstall = v && !fl && (hz1 || hz2 || (mr && sz == DEPTH && !ld));
    iss    = v && mr && rd != 0 && !mstall && !fl;
    popping = ld && sz > 0;
    kill   = fl && exl && sz > 0 && !(popping && sz == 1);
    if (ld && sz == 0 && !iss) m_err = 1'b1;
    if (popping) void'(m_q.pop_front());
    if (kill) void'(m_q.pop_back());
    if (iss) begin
      if (m_q.size() == DEPTH) m_err = 1'b1;
      else m_q.push_back(rd);
    end
    e.stall = mstall;
    e.full  = (m_q.size() == DEPTH);
    e.empty = (m_q.size() == 0);
    e.cnt   = 3'(m_q.size());
    e.err   = m_err;
    exp_q.push_back(e);
    obs_stall = stall;
    stall_cycles += int'(obs_stall);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("stall", obs_stall, e.stall);
    check_eq("full", full, e.full);
    check_eq("empty", empty, e.empty);
    check_eq("pending_cnt", pending_cnt, e.cnt);
    check_eq("err", err, e.err);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic done_only();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic ld_issue(input logic [4:0] rd, input logic ld);
    cyc(1, 0, 0, 0, 0, rd, 1, 0, 0, ld);
  endtask

  task automatic use_op(input logic [4:0] r1, input logic [4:0] r2, input logic exl,
                        input logic ld);
    cyc(1, r1, r2, 1, 1, 5'd6, 0, 0, exl, ld);
  endtask

  task automatic kill_cyc(input logic ld);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, ld);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"}, stall, 1'b0);
    check_eq({tag, "_full"}, full, 1'b0);
    check_eq({tag, "_empty"}, empty, 1'b1);
    check_eq({tag, "_cnt"}, pending_cnt, 3'd0);
    check_eq({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_memread = 0; flush = 0; ex_is_load = 0; load_done = 0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back load-use, 1-cycle memory: one stall cycle.
    stall_cycles = 0;
    ld_issue(5, 0);
    use_op(5, 1, 1, 0);
    use_op(5, 1, 1, 1);
    idle();
    check_eq("s1_stall_cycles", 8'(stall_cycles), 8'd1);

    // Latency 4: stall held 4 cycles, released on load_done.
    stall_cycles = 0;
    ld_issue(5, 0);
    repeat (4) use_op(5, 0, 1, 0);
    use_op(5, 0, 1, 1);
    check_eq("s2_stall_cycles", 8'(stall_cycles), 8'd4);

    // Loads to x0 are never tracked.
    stall_cycles = 0;
    ld_issue(0, 0);
    use_op(0, 0, 0, 0);
    check_eq("s3_stall_cycles", 8'(stall_cycles), 8'd0);
    check_eq("s3_empty", empty, 1'b1);

    // Fill, stall on 5th load, then issue it alongside a completion.
    for (int i = 1; i <= 4; i++) ld_issue(5'(i), 0);
    check_eq("s4_full", full, 1'b1);
    ld_issue(9, 0);
    ld_issue(9, 1);
    check_eq("s4_cnt_after_swap", pending_cnt, 3'd4);
    use_op(2, 9, 0, 0);
    repeat (4) done_only();

    // Kill a flushed load; then kill coinciding with completion.
    ld_issue(7, 0);
    kill_cyc(0);
    check_eq("s5_empty_after_kill", empty, 1'b1);
    stall_cycles = 0;
    use_op(7, 7, 0, 0);
    check_eq("s5_no_stall", 8'(stall_cycles), 8'd0);
    ld_issue(7, 0);
    kill_cyc(1);
    check_eq("s5_same_load_err", err, 1'b0);
    ld_issue(1, 0);
    ld_issue(2, 0);
    kill_cyc(1);
    check_eq("s5_pop_and_drop_cnt", pending_cnt, 3'd0);
    use_op(1, 2, 0, 0);

    // Spurious completion sets a sticky error.
    done_only();
    idle();
    idle();
    check_eq("s6_err_sticky", err, 1'b1);
    rst = 1'b1;
    #2;
    check_reset_outputs("rst_clears_err");
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_err = 1'b0;

    // Asynchronous reset with three loads outstanding.
    ld_issue(1, 0);
    ld_issue(2, 0);
    ld_issue(3, 0);
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 1; id_memread = 0;
    #1;
    check_eq("pre_rst_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    m_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    use_op(1, 2, 0, 0);
    done_only();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Producer-side hazard block for the 5-stage core.
- Tracks destination registers of in-flight loads from issue (ID→EX) until the memory returns their data. It stalls ID when a source operand depends on a load whose data cannot yet be forwarded.
- Complements operand forwarding: ALU results are always forwarded and never tracked here; loads become forwardable from MEM/WB once their data returns.
- Supports variable-latency data memory with in-order load completion.

Parameters:
- DEPTH, 4, maximum outstanding loads (tag FIFO depth, ≥2).
- CNT_W, 3, width of per-register pending counters and of pending_cnt; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1  in  5  ID source 1
- id_rs2  in  5  ID source 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  5  ID destination
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump flush: kills the ID and EX instructions this cycle
- ex_is_load  in  1  EX holds a valid load that has not completed
- load_done  in  1  oldest outstanding load's data returns this cycle (enters MEM/WB next edge)
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- full  out  1  DEPTH loads outstanding
- empty  out  1  no loads outstanding
- pending_cnt  out  CNT_W  outstanding load count
- err  out  1  sticky protocol error

Behaviour:
- Reset, asynchronous:
  - FIFO pointers and counts are 0; all 32 per-register pending counters are 0.
  - err=0, empty=1, full=0, pending_cnt=0, stall=0.
- State:
  - tag FIFO of DEPTH×5-bit rd values, with head, tail and count;
  - pend[0..31], each CNT_W bits.
- Issue: issue = id_valid & id_memread & (id_rd≠0) & ~stall & ~flush.
  - On the edge: push id_rd at tail and increment pend[id_rd].
  - A load to x0 is never tracked.
- Completion: on load_done with count>0, pop the head and decrement pend[head].
- Kill: kill = flush & ex_is_load & count>0. On the edge: drop the tail entry (tail−1) and decrement pend[that rd].
- Same cycle, count==1, load_done and kill both asserted: this is the same load. Completion wins and kill is ignored, giving net count 0.
- Same cycle, count≥2, load_done and kill both asserted: pop head and drop tail together (count−2).
- Same cycle, issue and load_done: push and pop both apply; count is unchanged.
- Issue and kill never coincide, because flush gates issue.
- Hazard on an operand X ∈ {rs1, rs2}: use_X & X≠0 & pend[X]≠0 & ~release_X.
  - release_X = load_done & (tag[head]==X) & (pend[X]==1). Data returned this cycle is forwardable from MEM/WB next cycle.
- stall = id_valid & ~flush & (hazard_rs1 | hazard_rs2 | (id_memread & full & ~load_done)).
  - stall is combinational from registered state plus current inputs; 0-cycle latency.
- Stall release: a load-use dependence stalls exactly until the cycle its load_done asserts, and releases in that cycle.
- Minimum penalty: a back-to-back load-use with 1-cycle memory gives 1 stall cycle (load in EX, load_done in MEM).
- full = (count==DEPTH); empty = (count==0); pending_cnt = count; all registered.
- err is set on any of the following, and held until reset:
  - load_done while empty, without issue in the same cycle;
  - a push while full;
  - a pend counter underflow.
  - The offending pop or decrement is suppressed; state is otherwise unchanged.
- Pointers wrap modulo DEPTH. A non-power-of-2 DEPTH requires explicit compare-and-reset.
- rst asserted mid-operation discards all outstanding tags. Memory responses arriving after reset are the memory side's responsibility; if they do arrive, they set err.

Decomposition:
- Shared core package holds:
  - REG_ADDR_W=5 and the x0 constant;
  - a typedef for the FIFO entry (rd only);
  - the hazard-cause encoding, for debug/perf counters.
- Natural sub-module: tag_fifo, a parameterised DEPTH×5 FIFO with push, pop, drop_tail, head/tail data, count, full and empty.
- The per-register pending counters and the stall logic stay in the top.

Test Plan:
- Load x5, then add x6,x5,x1 next cycle, load_done 1 cycle after issue → stall=1 for exactly 1 cycle, deasserted in the load_done cycle; pending_cnt 1→0.
- Load x5, then use x5 with memory latency 4 → stall held 4 cycles, released on the load_done cycle; no extra bubble.
- Load x0, then use x0 → no entry pushed, stall never asserts, empty stays 1.
- DEPTH=4: issue 4 loads to x1..x4, then a 5th load → full=1 and stall=1. Assert load_done → the 5th issues that cycle and pending_cnt stays 4.
- Load x7 issued, next cycle flush with ex_is_load=1 → entry dropped, pend[x7]=0, empty=1, no stall on later x7 use. Repeat with load_done in the same cycle → count 0, err=0.
- load_done while empty → err=1 and sticky; count stays 0. Assert rst mid-run with 3 loads outstanding → all outputs at reset values immediately (asynchronous).
